// File: rtl/mitm_pkg.sv
// Shared definitions for the MITM mode engine: mode codes, TX handshake
// states and the letter-rotation helpers used by the ROT transform.
package mitm_pkg;

  localparam int NUM_MODES = 5;

  localparam logic [NUM_MODES-1:0] MODE_FORWARD     = 5'b00001;
  localparam logic [NUM_MODES-1:0] MODE_SUB0_BLOCK1 = 5'b00010;
  localparam logic [NUM_MODES-1:0] MODE_SUB1_BLOCK0 = 5'b00100;
  localparam logic [NUM_MODES-1:0] MODE_ROT         = 5'b01000;
  localparam logic [NUM_MODES-1:0] MODE_XOR         = 5'b10000;

  typedef enum logic [1:0] {
    TX_IDLE        = 2'd0,
    TX_START       = 2'd1,
    TX_WAIT_ACCEPT = 2'd2,
    TX_WAIT_DONE   = 2'd3
  } tx_state_t;

  localparam logic [7:0] CHAR_UPPER_A = 8'h41;
  localparam logic [7:0] CHAR_UPPER_Z = 8'h5A;
  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_Z = 8'h7A;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CHAR_UPPER_A) && (c <= CHAR_UPPER_Z)) ||
           ((c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_Z));
  endfunction

  // Caller guarantees c is a letter and shift is 0..25; case is preserved.
  function automatic logic [7:0] rot_letter(input logic [7:0] c, input logic [4:0] shift);
    logic [7:0] base;
    logic [7:0] off;
    base = (c >= CHAR_LOWER_A) ? CHAR_LOWER_A : CHAR_UPPER_A;
    off  = c - base + {3'b000, shift};
    if (off >= 8'd26) off = off - 8'd26;
    return base + off;
  endfunction

  function automatic logic [7:0] rot_fwd(input logic [7:0] c, input logic [4:0] key);
    return is_letter(c) ? rot_letter(c, key) : c;
  endfunction

  // Inverse rotation is a forward rotation by the complement within the alphabet.
  function automatic logic [7:0] rot_inv(input logic [7:0] c, input logic [4:0] key);
    logic [4:0] shift;
    shift = (key == 5'd0) ? 5'd0 : (5'd26 - key);
    return is_letter(c) ? rot_letter(c, shift) : c;
  endfunction

endpackage

// File: rtl/mitm_tx_queue.sv
// Per-direction word buffer with sticky drop flag and a send handshake FSM.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// TX_IDLE        | waiting for a buffered word and an idle transmitter
// TX_START       | start pulse out, head word presented, head popped
// TX_WAIT_ACCEPT | waiting for the transmitter to drop send_ready
// TX_WAIT_DONE   | waiting for the transmitter to raise send_ready again
module mitm_tx_queue
  import mitm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              send_ready,
  output logic              send_start,
  output logic [DATA_W-1:0] send_data,
  output logic              empty,
  output logic              idle,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  tx_state_t         state;
  tx_state_t         state_nxt;
  logic              load;
  logic              full;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  // A full buffer still accepts a word in the cycle its head is popped.
  assign push_ok = push && (!full || send_start);

  // Storage write; contents need no reset because count governs validity.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)    wr_ptr <= wr_ptr + 1'b1;
      if (send_start) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, send_start})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !send_start) overflow <= 1'b1;
    end
  end

  // State register and outgoing word, latched as the FSM enters TX_START.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      send_data <= '0;
    end else begin
      state <= state_nxt;
      if (load) send_data <= mem[rd_ptr];
    end
  end

  // Handshake sequencing and per-state outputs.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    send_start = 1'b0;
    idle       = 1'b0;
    case (state)
      TX_IDLE: begin
        idle = 1'b1;
        if (!empty && send_ready) begin
          state_nxt = TX_START;
          load      = 1'b1;
        end
      end
      TX_START: begin
        send_start = 1'b1;
        state_nxt  = TX_WAIT_ACCEPT;
      end
      TX_WAIT_ACCEPT: if (!send_ready) state_nxt = TX_WAIT_DONE;
      TX_WAIT_DONE:   if (send_ready)  state_nxt = TX_IDLE;
      default:        state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/mitm_mode_engine.sv
// MITM mode engine: transforms intercepted words per the active mode,
// buffers them per direction and replays them on the fake send path.
// Mode changes wait until both directions are fully drained.
module mitm_mode_engine
  import mitm_pkg::*;
#(
  parameter int         NUM_DATA_BITS = 8,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         ROT_KEY       = 13,
  parameter logic [7:0] XOR_KEY       = 8'h20,
  parameter logic [7:0] SUB_CHAR0     = 8'h23,
  parameter logic [7:0] SUB_CHAR1     = 8'h24
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [NUM_MODES-1:0]     mode_select,
  output logic [NUM_MODES-1:0]     mode_active,
  output logic                     mode_pending,
  input  logic                     if0_recv_new_data_ready,
  input  logic                     if1_recv_new_data_ready,
  input  logic [NUM_DATA_BITS-1:0] real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0] real_if1_recv_data,
  input  logic                     if0_send_ready,
  input  logic                     if1_send_ready,
  output logic                     fake_if0_send_select,
  output logic                     fake_if1_send_select,
  output logic                     fake_if0_send_start,
  output logic                     fake_if1_send_start,
  output logic [NUM_DATA_BITS-1:0] fake_if0_send_data,
  output logic [NUM_DATA_BITS-1:0] fake_if1_send_data,
  output logic [1:0]               overflow
);

  localparam logic [4:0]               ROT_KEY_W = 5'(ROT_KEY);
  localparam logic [NUM_DATA_BITS-1:0] XOR_MASK  = NUM_DATA_BITS'(XOR_KEY);
  localparam logic [NUM_DATA_BITS-1:0] SUB0_W    = NUM_DATA_BITS'(SUB_CHAR0);
  localparam logic [NUM_DATA_BITS-1:0] SUB1_W    = NUM_DATA_BITS'(SUB_CHAR1);

  logic [NUM_MODES-1:0]     mode_req;
  logic                     fake_select;
  logic                     push_01, push_10;
  logic [NUM_DATA_BITS-1:0] push_data_01, push_data_10;
  logic                     empty_01, empty_10, idle_01, idle_10;
  logic                     drained;

  // Only plain bytes are rotated; anything with upper bits set passes through.
  function automatic logic [NUM_DATA_BITS-1:0] rot_word(input logic [NUM_DATA_BITS-1:0] w,
                                                        input logic inv);
    logic [NUM_DATA_BITS-1:0] r;
    r = w;
    if ((w >> 8) == '0) r[7:0] = inv ? rot_inv(w[7:0], ROT_KEY_W) : rot_fwd(w[7:0], ROT_KEY_W);
    return r;
  endfunction

  assign mode_pending         = (mode_req != mode_active);
  assign drained              = empty_01 && empty_10 && idle_01 && idle_10 &&
                                !if0_recv_new_data_ready && !if1_recv_new_data_ready;
  assign fake_if0_send_select = fake_select;
  assign fake_if1_send_select = fake_select;

  // Request capture, deferred mode application, and select lagging mode by one cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mode_req    <= MODE_FORWARD;
      mode_active <= MODE_FORWARD;
      fake_select <= 1'b0;
    end else begin
      if ($onehot(mode_select)) mode_req <= mode_select;
      if (mode_pending && drained) mode_active <= mode_req;
      fake_select <= (mode_active != MODE_FORWARD);
    end
  end

  // Push decision and transformed word per direction under the active mode.
  always_comb begin
    push_01      = 1'b0;
    push_10      = 1'b0;
    push_data_01 = '0;
    push_data_10 = '0;
    case (mode_active)
      MODE_SUB0_BLOCK1: begin
        push_01      = if0_recv_new_data_ready;
        push_data_01 = SUB1_W;
      end
      MODE_SUB1_BLOCK0: begin
        push_10      = if1_recv_new_data_ready;
        push_data_10 = SUB0_W;
      end
      MODE_ROT: begin
        push_01      = if0_recv_new_data_ready;
        push_data_01 = rot_word(real_if0_recv_data, 1'b0);
        push_10      = if1_recv_new_data_ready;
        push_data_10 = rot_word(real_if1_recv_data, 1'b1);
      end
      MODE_XOR: begin
        push_01      = if0_recv_new_data_ready;
        push_data_01 = real_if0_recv_data ^ XOR_MASK;
        push_10      = if1_recv_new_data_ready;
        push_data_10 = real_if1_recv_data ^ XOR_MASK;
      end
      default: ;
    endcase
  end

  mitm_tx_queue #(.DATA_W(NUM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_q01 (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .push       (push_01),
    .push_data  (push_data_01),
    .send_ready (if1_send_ready),
    .send_start (fake_if1_send_start),
    .send_data  (fake_if1_send_data),
    .empty      (empty_01),
    .idle       (idle_01),
    .overflow   (overflow[0])
  );

  mitm_tx_queue #(.DATA_W(NUM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_q10 (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .push       (push_10),
    .push_data  (push_data_10),
    .send_ready (if0_send_ready),
    .send_start (fake_if0_send_start),
    .send_data  (fake_if0_send_data),
    .empty      (empty_10),
    .idle       (idle_10),
    .overflow   (overflow[1])
  );

endmodule

// File: tb/tb_mitm_mode_engine.sv
// Bench for mitm_mode_engine: directed traffic, a per-cycle reference model
// of modes, buffering and handshakes, plus literal expectations.
module tb_mitm_mode_engine;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   mode_select = 5'b00001;
  logic [4:0]   mode_active;
  logic         mode_pending;
  logic         if0_recv_new_data_ready = 1'b0, if1_recv_new_data_ready = 1'b0;
  logic [W-1:0] real_if0_recv_data = '0, real_if1_recv_data = '0;
  logic         if0_send_ready, if1_send_ready;
  logic         fake_if0_send_select, fake_if1_send_select;
  logic         fake_if0_send_start, fake_if1_send_start;
  logic [W-1:0] fake_if0_send_data, fake_if1_send_data;
  logic [1:0]   overflow;

  bit hold0 = 1'b0, hold1 = 1'b0;
  int checks = 0, failures = 0;

  always #5 sys_clk = ~sys_clk;

  mitm_mode_engine #(
    .NUM_DATA_BITS(W), .FIFO_DEPTH(DEPTH), .ROT_KEY(13),
    .XOR_KEY(8'h20), .SUB_CHAR0(8'h23), .SUB_CHAR1(8'h24)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .mode_select(mode_select), .mode_active(mode_active), .mode_pending(mode_pending),
    .if0_recv_new_data_ready(if0_recv_new_data_ready),
    .if1_recv_new_data_ready(if1_recv_new_data_ready),
    .real_if0_recv_data(real_if0_recv_data), .real_if1_recv_data(real_if1_recv_data),
    .if0_send_ready(if0_send_ready), .if1_send_ready(if1_send_ready),
    .fake_if0_send_select(fake_if0_send_select), .fake_if1_send_select(fake_if1_send_select),
    .fake_if0_send_start(fake_if0_send_start), .fake_if1_send_start(fake_if1_send_start),
    .fake_if0_send_data(fake_if0_send_data), .fake_if1_send_data(fake_if1_send_data),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Direction index d: 1 = words heading to if1 (from if0), 0 = heading to if0.
  logic [7:0] mbuf [2][16];
  int         mrd [2];
  int         mn [2];
  bit         due [2];      // a start pulse is owed this cycle
  bit         alow [2];     // after a start, waiting for ready to fall
  bit         ahigh [2];    // after ready fell, waiting for it to rise
  logic [4:0] m_req, m_active;
  bit         m_sel;
  logic [1:0] m_ov;
  bit         model_ok = 1'b0;

  function automatic logic [7:0] m_rot(input logic [7:0] c, input int k);
    int base;
    if (c >= 8'd65 && c <= 8'd90) base = 65;
    else if (c >= 8'd97 && c <= 8'd122) base = 97;
    else return c;
    return 8'(base + ((int'(c) - base + k + 26) % 26));
  endfunction

  function automatic bit model_drained();
    return mn[0] == 0 && mn[1] == 0 && !due[0] && !due[1] &&
           !alow[0] && !alow[1] && !ahigh[0] && !ahigh[1];
  endfunction

  // Compare DUT against the model, then advance the model across the next edge.
  always @(negedge sys_clk) begin
    logic       st [2];
    logic [7:0] dout [2];
    logic       rdy [2];
    logic       rcv [2];
    logic [7:0] rcvd [2];
    bit         drained, fr, p, nxt;
    logic [7:0] pd;
    st[0] = fake_if0_send_start;  st[1] = fake_if1_send_start;
    dout[0] = fake_if0_send_data; dout[1] = fake_if1_send_data;
    rdy[0] = if0_send_ready;      rdy[1] = if1_send_ready;
    rcv[1] = if0_recv_new_data_ready; rcvd[1] = real_if0_recv_data;
    rcv[0] = if1_recv_new_data_ready; rcvd[0] = real_if1_recv_data;
    if (model_ok) begin
      check("mode_active", 32'(mode_active), 32'(m_active));
      check("mode_pending", 32'(mode_pending), 32'(m_req != m_active));
      check("select0", 32'(fake_if0_send_select), 32'(m_sel));
      check("select1", 32'(fake_if1_send_select), 32'(m_sel));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("start0", 32'(st[0]), 32'(due[0]));
      check("start1", 32'(st[1]), 32'(due[1]));
      for (int d = 0; d < 2; d++)
        if (due[d] && st[d]) check(d ? "data1" : "data0", 32'(dout[d]), 32'(mbuf[d][mrd[d]]));
    end
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mrd[d] = 0; mn[d] = 0; due[d] = 0; alow[d] = 0; ahigh[d] = 0;
      end
      m_req = 5'b00001; m_active = 5'b00001; m_sel = 0; m_ov = 2'b00;
      model_ok = 1'b1;
    end else if (model_ok) begin
      drained = model_drained() && !rcv[0] && !rcv[1];
      for (int d = 0; d < 2; d++) begin
        fr  = !due[d] && !alow[d] && !ahigh[d];
        nxt = fr && mn[d] > 0 && rdy[d];
        p = 0; pd = 8'h00;
        case (m_active)
          5'b00010: if (d == 1) begin p = rcv[d]; pd = 8'h24; end
          5'b00100: if (d == 0) begin p = rcv[d]; pd = 8'h23; end
          5'b01000: begin p = rcv[d]; pd = m_rot(rcvd[d], d == 1 ? 13 : -13); end
          5'b10000: begin p = rcv[d]; pd = rcvd[d] ^ 8'h20; end
          default: ;
        endcase
        if (p) begin
          if (mn[d] < DEPTH || due[d]) begin
            mbuf[d][(mrd[d] + mn[d]) % 16] = pd;
            mn[d]++;
          end else m_ov[d == 1 ? 0 : 1] = 1'b1;
        end
        if (due[d]) begin
          mrd[d] = (mrd[d] + 1) % 16;
          mn[d]--;
          alow[d] = 1;
        end else if (alow[d] && !rdy[d]) begin
          alow[d] = 0; ahigh[d] = 1;
        end else if (ahigh[d] && rdy[d]) ahigh[d] = 0;
        due[d] = nxt;
      end
      m_sel = (m_active != 5'b00001);
      if (m_req != m_active && drained) m_active = m_req;
      if ($countones(mode_select) == 1) m_req = mode_select;
    end
  end

  // ---------------- peer transmitters ----------------
  // Each peer drops ready for three cycles after a start, or while held.
  initial begin : resp0
    int lo; bit saw;
    lo = 0; if0_send_ready = 1'b1;
    forever begin
      @(negedge sys_clk); saw = fake_if0_send_start;
      @(posedge sys_clk); #1;
      if (saw) lo = 3;
      if0_send_ready = !(hold0 || lo > 0);
      if (lo > 0) lo--;
    end
  end

  initial begin : resp1
    int lo; bit saw;
    lo = 0; if1_send_ready = 1'b1;
    forever begin
      @(negedge sys_clk); saw = fake_if1_send_start;
      @(posedge sys_clk); #1;
      if (saw) lo = 3;
      if1_send_ready = !(hold1 || lo > 0);
      if (lo > 0) lo--;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge sys_clk); #1;
  endtask

  task automatic recv0(input logic [7:0] v);
    real_if0_recv_data = v; if0_recv_new_data_ready = 1'b1;
    cyc();
    if0_recv_new_data_ready = 1'b0;
  endtask

  task automatic recv1(input logic [7:0] v);
    real_if1_recv_data = v; if1_recv_new_data_ready = 1'b1;
    cyc();
    if1_recv_new_data_ready = 1'b0;
  endtask

  task automatic expect_send(input int dir, input logic [7:0] val, input string name);
    int n; bit got;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge sys_clk);
      if (dir == 1 ? fake_if1_send_start : fake_if0_send_start) got = 1;
      n++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: no start pulse within 60 cycles, expected data %0h", name, val);
    end else if ((dir == 1 ? fake_if1_send_data : fake_if0_send_data) !== val) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name,
               dir == 1 ? fake_if1_send_data : fake_if0_send_data, val);
    end
  endtask

  task automatic wait_mode(input logic [4:0] m, input string name);
    int n;
    n = 0;
    while (mode_active !== m && n < 100) begin cyc(); n++; end
    check(name, 32'(mode_active), 32'(m));
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while (!model_drained() && n < 200) begin cyc(); n++; end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s: traffic still outstanding after 200 cycles, required drained", name);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got0, got1;
    int n;
    logic [7:0] d0, d1;
    repeat (3) cyc();
    rst = 1'b0;
    check("reset_mode_active", 32'(mode_active), 32'h01);
    check("reset_pending", 32'(mode_pending), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_data1", 32'(fake_if1_send_data), 32'h0);

    // forward: nothing is intercepted
    recv0(8'h41);
    repeat (6) cyc();
    check("fwd_select0", 32'(fake_if0_send_select), 32'h0);
    check("fwd_overflow", 32'(overflow), 32'h0);

    // rotation in both directions
    mode_select = 5'b01000;
    wait_mode(5'b01000, "rot_applied");
    cyc();
    check("rot_select1", 32'(fake_if1_send_select), 32'h1);
    recv0(8'h61); expect_send(1, 8'h6E, "rot_a");     wait_drained("rot_a_drain");
    recv0(8'h5A); expect_send(1, 8'h4D, "rot_Z");     wait_drained("rot_Z_drain");
    recv1(8'h6E); expect_send(0, 8'h61, "rot_inv_n"); wait_drained("rot_n_drain");
    recv0(8'h35); expect_send(1, 8'h35, "rot_digit"); wait_drained("rot_5_drain");

    // overflow: five words into a four-deep buffer while if1 is busy
    mode_select = 5'b10000;
    wait_mode(5'b10000, "xor_applied");
    hold1 = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 5; i++) begin
      recv0(8'h61 + 8'(i));
      cyc();
    end
    check("xor_overflow", 32'(overflow), 32'h1);
    hold1 = 1'b0;
    for (int i = 0; i < 4; i++) expect_send(1, 8'h41 + 8'(i), "xor_order");
    wait_drained("xor_drain");
    repeat (10) cyc();

    // deferred switch: request forward while two substituted words wait
    mode_select = 5'b00010;
    wait_mode(5'b00010, "sub_applied");
    hold1 = 1'b1;
    repeat (2) cyc();
    recv0(8'h10);
    cyc();
    recv0(8'h11);
    mode_select = 5'b00001;
    repeat (3) cyc();
    check("defer_pending", 32'(mode_pending), 32'h1);
    check("defer_still_sub", 32'(mode_active), 32'h02);
    hold1 = 1'b0;
    expect_send(1, 8'h24, "sub_word0");
    expect_send(1, 8'h24, "sub_word1");
    check("defer_pending_late", 32'(mode_pending), 32'h1);
    wait_mode(5'b00001, "defer_forward");
    check("defer_pending_clear", 32'(mode_pending), 32'h0);
    cyc();
    check("defer_select_drop", 32'(fake_if1_send_select), 32'h0);

    // invalid request is ignored; the previous valid one remains in force
    mode_select = 5'b01000;
    wait_mode(5'b01000, "rot_again");
    mode_select = 5'b00110;
    repeat (5) cyc();
    check("invalid_active", 32'(mode_active), 32'h08);
    check("invalid_pending", 32'(mode_pending), 32'h0);

    // simultaneous traffic, then reset mid-handshake
    real_if0_recv_data = 8'h41; real_if1_recv_data = 8'h7A;
    if0_recv_new_data_ready = 1'b1; if1_recv_new_data_ready = 1'b1;
    cyc();
    if0_recv_new_data_ready = 1'b0; if1_recv_new_data_ready = 1'b0;
    got0 = 0; got1 = 0; n = 0; d0 = 8'h00; d1 = 8'h00;
    while (!(got0 && got1) && n < 40) begin
      @(negedge sys_clk);
      if (fake_if0_send_start) begin got0 = 1; d0 = fake_if0_send_data; end
      if (fake_if1_send_start) begin got1 = 1; d1 = fake_if1_send_data; end
      n++;
    end
    check("dual_start0", 32'(got0), 32'h1);
    check("dual_start1", 32'(got1), 32'h1);
    check("dual_data0", 32'(d0), 32'h6D);
    check("dual_data1", 32'(d1), 32'h4E);
    @(posedge sys_clk); #1;
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_start0", 32'(fake_if0_send_start), 32'h0);
    check("rst_start1", 32'(fake_if1_send_start), 32'h0);
    check("rst_select", 32'({fake_if0_send_select, fake_if1_send_select}), 32'h0);
    check("rst_mode", 32'(mode_active), 32'h01);
    check("rst_data", 32'({fake_if0_send_data, fake_if1_send_data}), 32'h0);
    rst = 1'b0;
    repeat (10) cyc();
    wait_drained("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
